// File: rtl/particle_rasterizer.sv
// particle_rasterizer: fp16 particle stream to double-buffered 1-plane framebuffer with swap/clear control
// Define PARTICLE_COLOR_BY_INDEX_EN to colour each particle from the low bits of its index.
module particle_rasterizer #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int CENTER_X = 160,
  parameter int CENTER_Y = 120,
  parameter int PIX_SHIFT = 4,
  parameter int COUNTER_SIZE = 16,
  parameter int COLOR_W = 4,
  parameter logic [COLOR_W-1:0] PARTICLE_COLOR = 4'hF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic particle_valid_in,
  input  logic [COUNTER_SIZE-1:0] particle_index_in,
  input  logic [31:0] particle_pos_in,
  input  logic frame_complete_in,
  output logic [$clog2(2*SCREEN_W*SCREEN_H)-1:0] fb_addr_out,
  output logic [COLOR_W-1:0] fb_data_out,
  output logic fb_we_out,
  output logic front_buffer_out,
  output logic clearing_out,
  output logic [15:0] clip_count_out,
  output logic [15:0] drop_count_out
);
  localparam int NPIX = SCREEN_W * SCREEN_H;
  localparam int AW = $clog2(2 * NPIX);
  localparam int OW = $clog2(NPIX);
  localparam int PW = $clog2(FIFO_DEPTH) + 1;
  localparam int SH = 6 - PIX_SHIFT;
`ifdef PARTICLE_COLOR_BY_INDEX_EN
  localparam int DW = 32 + COLOR_W;
`else
  localparam int DW = 32;
`endif

  typedef enum logic [1:0] {CLEAR, DRAW, DRAIN, SWAP} state_t;
  state_t state, state_nx;

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [DW-1:0] din, head;
  logic empty, full, push, pop, drop, clr, pend;
  logic [OW-1:0] clr_cnt;
  logic [AW-1:0] back_base;
  logic [COLOR_W-1:0] pcol;
  logic unused_idx;

  logic s1_v;
  logic [17:0] s1_x, s1_y;
  logic [COLOR_W-1:0] s1_c;
  logic signed [16:0] fx, fy;
  logic signed [17:0] px, py;
  logic clip2;
  logic [OW-1:0] off2;
  logic s2_v, s2_clip;
  logic [OW-1:0] s2_off;
  logic [COLOR_W-1:0] s2_c;

  // Returns {clip, signed Q.6 value}; exponents >= 24 cover |v| >= 512, inf and NaN.
  function automatic logic [17:0] to_fix(input logic [15:0] h);
    logic [16:0] man, mag;
    man = {6'd0, 1'b1, h[9:0]};
    mag = (h[14:10] < 5'd9) ? '0 :
          (h[14:10] >= 5'd19) ? man << (h[14:10] - 5'd19) : man >> (5'd19 - h[14:10]);
    return {h[14:10] >= 5'd24, h[15] ? -mag : mag};
  endfunction

  assign unused_idx = ^particle_index_in;
`ifdef PARTICLE_COLOR_BY_INDEX_EN
  assign din = {particle_index_in[COLOR_W-1:0], particle_pos_in};
  assign pcol = (head[DW-1:32] == '0) ? PARTICLE_COLOR : head[DW-1:32];
`else
  assign din = particle_pos_in;
  assign pcol = PARTICLE_COLOR;
`endif

  assign head = mem[rp[PW-2:0]];
  assign empty = wp == rp;
  assign full = wp == {~rp[PW-1], rp[PW-2:0]};
  assign push = particle_valid_in && (!full || pop);
  assign drop = particle_valid_in && full && !pop;
  assign back_base = front_buffer_out ? '0 : AW'(NPIX);

  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) state <= CLEAR;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      CLEAR: if (clr_cnt == OW'(NPIX - 1)) state_nx = DRAW;
      DRAW: if (frame_complete_in || pend) state_nx = DRAIN;
      DRAIN: if (empty && !s1_v && !s2_v) state_nx = SWAP;
      default: state_nx = CLEAR;
    endcase
  end

  always_comb begin
    pop = (state == DRAW || state == DRAIN) && !empty;
    clr = state == CLEAR;
    clearing_out = state == CLEAR;
  end

  always_ff @(posedge clk_in)
    if (push) mem[wp[PW-2:0]] <= din;

  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      wp <= '0;
      rp <= '0;
      pend <= 1'b0;
      front_buffer_out <= 1'b0;
      clr_cnt <= '0;
      clip_count_out <= '0;
      drop_count_out <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      pend <= (state == DRAW) ? 1'b0 : (pend || frame_complete_in);
      if (state == SWAP) front_buffer_out <= ~front_buffer_out;
      clr_cnt <= clr ? clr_cnt + 1'b1 : '0;
      if (state == SWAP) clip_count_out <= '0;
      else if (s2_v && s2_clip && clip_count_out != 16'hFFFF) clip_count_out <= clip_count_out + 1'b1;
      if (drop && drop_count_out != 16'hFFFF) drop_count_out <= drop_count_out + 1'b1;
    end

  always_comb begin
    fx = s1_x[16:0];
    fy = s1_y[16:0];
    px = 18'(CENTER_X) + 18'(fx >>> SH);
    py = 18'(CENTER_Y) - 18'(fy >>> SH);
    clip2 = s1_x[17] || s1_y[17] || px[17] || py[17] || px >= 18'(SCREEN_W) || py >= 18'(SCREEN_H);
    off2 = OW'(int'(py) * SCREEN_W + int'(px));
  end

  // Stage 1 converts both coordinates, stage 2 maps to a pixel offset, stage 3 is the output register.
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      s1_v <= 1'b0;
      s1_x <= '0;
      s1_y <= '0;
      s1_c <= '0;
      s2_v <= 1'b0;
      s2_clip <= 1'b0;
      s2_off <= '0;
      s2_c <= '0;
    end else begin
      s1_v <= pop;
      s1_x <= to_fix(head[31:16]);
      s1_y <= to_fix(head[15:0]);
      s1_c <= pcol;
      s2_v <= s1_v;
      s2_clip <= clip2;
      s2_off <= off2;
      s2_c <= s1_c;
    end

  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      fb_we_out <= 1'b0;
      fb_addr_out <= '0;
      fb_data_out <= '0;
    end else if (clr) begin
      fb_we_out <= 1'b1;
      fb_addr_out <= back_base + AW'(clr_cnt);
      fb_data_out <= '0;
    end else begin
      fb_we_out <= s2_v && !s2_clip;
      if (s2_v && !s2_clip) begin
        fb_addr_out <= back_base + AW'(s2_off);
        fb_data_out <= s2_c;
      end
    end
endmodule

// File: tb/tb_particle_rasterizer.sv
// tb_particle_rasterizer: randomized and directed checks of particle_rasterizer against a real-arithmetic reference model
// A reduced screen keeps each buffer clear short; the model is parameterised on the same geometry.
module tb_particle_rasterizer;
  localparam int W = 64, H = 48, CX = 32, CY = 24, PS = 2, DEPTH = 8;
  localparam int NPIX = W * H;
  localparam int AW = $clog2(2 * NPIX);

  logic clk_in = 1'b0, rst_in = 1'b1, particle_valid_in = 1'b0, frame_complete_in = 1'b0;
  logic [15:0] particle_index_in = '0;
  logic [31:0] particle_pos_in = '0;
  logic [AW-1:0] fb_addr_out;
  logic [3:0] fb_data_out;
  logic fb_we_out, front_buffer_out, clearing_out;
  logic [15:0] clip_count_out, drop_count_out;

  typedef struct {int addr; int data; longint cyc;} wr_t;
  wr_t obs_q[$], exp_q[$];
  int checks = 0, failures = 0, clip_exp = 0, back_base = NPIX;
  longint cyc = 0, drv_cyc = 0, lat = 0;

  particle_rasterizer #(.SCREEN_W(W), .SCREEN_H(H), .CENTER_X(CX), .CENTER_Y(CY), .PIX_SHIFT(PS),
    .COUNTER_SIZE(16), .COLOR_W(4), .PARTICLE_COLOR(4'hF), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .particle_valid_in(particle_valid_in),
    .particle_index_in(particle_index_in), .particle_pos_in(particle_pos_in),
    .frame_complete_in(frame_complete_in), .fb_addr_out(fb_addr_out), .fb_data_out(fb_data_out),
    .fb_we_out(fb_we_out), .front_buffer_out(front_buffer_out), .clearing_out(clearing_out),
    .clip_count_out(clip_count_out), .drop_count_out(drop_count_out));

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  always @(negedge clk_in) if (fb_we_out) obs_q.push_back('{int'(fb_addr_out), int'(fb_data_out), cyc});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // World coordinate -> pixel offset along one axis, using real arithmetic.
  function automatic void axis(input logic [15:0] h, output bit clip, output int o);
    int e, fix;
    real v;
    e = int'(h[14:10]);
    v = (e == 0) ? (h[9:0] / 1024.0) * 2.0 ** (-14) : (1.0 + h[9:0] / 1024.0) * 2.0 ** (e - 15);
    clip = (e == 31) || (v >= 512.0);
    fix = clip ? 0 : $rtoi(v * 64.0);
    if (h[15]) fix = -fix;
    o = $rtoi($floor(fix / 2.0 ** (6 - PS)));
  endfunction

  function automatic void model(input logic [31:0] pos, output bit clip, output int off);
    bit cx, cy;
    int ox, oy, px, py;
    axis(pos[31:16], cx, ox);
    axis(pos[15:0], cy, oy);
    px = CX + ox;
    py = CY - oy;
    clip = cx || cy || px < 0 || px >= W || py < 0 || py >= H;
    off = py * W + px;
  endfunction

  function automatic int color_of(input logic [15:0] idx);
`ifdef PARTICLE_COLOR_BY_INDEX_EN
    return (idx[3:0] == 4'd0) ? 15 : int'(idx[3:0]);
`else
    return 15;
`endif
  endfunction

  function automatic logic [15:0] rnd_h();
    logic [4:0] e;
    e = 5'($urandom_range(6, 20));
    if ($urandom_range(0, 9) == 0) e = 5'($urandom_range(21, 31));
    return {1'($urandom), e, 10'($urandom)};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  task automatic beat(input logic [31:0] pos, input logic [15:0] idx, input bit keep);
    bit clip;
    int off;
    particle_valid_in = 1'b1;
    particle_pos_in = pos;
    particle_index_in = idx;
    drv_cyc = cyc;
    if (keep) begin
      model(pos, clip, off);
      if (clip) clip_exp++;
      else exp_q.push_back('{back_base + off, color_of(idx), 0});
    end
    @(posedge clk_in); #1;
    particle_valid_in = 1'b0;
  endtask

  task automatic expect_clear(input int base);
    for (int i = 0; i < NPIX; i++) exp_q.push_back('{base + i, 0, 0});
  endtask

  task automatic wait_level(input bit lvl, input int limit, input string tag);
    int n = 0;
    while (clearing_out !== lvl && n < limit) begin @(posedge clk_in); #1; n++; end
    chk(tag, clearing_out, lvl);
  endtask

  task automatic compare_writes(input string tag);
    int bad = 0;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (obs_q[i].addr != exp_q[i].addr || obs_q[i].data != exp_q[i].data) bad++;
    chk({tag, "_content"}, bad, 0);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_we", fb_we_out, 0);
    chk("rst_addr", fb_addr_out, 0);
    chk("rst_data", fb_data_out, 0);
    chk("rst_front", front_buffer_out, 0);
    chk("rst_clearing", clearing_out, 1);
    chk("rst_clip", clip_count_out, 0);
    chk("rst_drop", drop_count_out, 0);
    rst_in = 1'b0;
    expect_clear(NPIX);
    wait_level(1'b0, NPIX + 50, "clear0_done");
    idle(3);
    compare_writes("clear0");
    chk("front_after_clear0", front_buffer_out, 0);

    beat({16'h0000, 16'h0000}, 16'h1234, 1'b1);
    lat = drv_cyc;
    idle(6);
    chk("latency", (obs_q.size() > 0) ? obs_q[0].cyc - lat : -1, 4);
    compare_writes("origin");

    beat({16'h3C00, 16'h3C00}, 16'h0001, 1'b1);
    beat({16'hC600, 16'h0000}, 16'h0020, 1'b1);
    beat({16'h4900, 16'h0000}, 16'h0003, 1'b1);
    beat({16'h7C00, 16'h0000}, 16'h0004, 1'b1);
    beat({16'h0000, 16'hC500}, 16'h0005, 1'b1);
    idle(8);
    compare_writes("directed");
    chk("clip_directed", clip_count_out, clip_exp);

    for (int i = 0; i < 24; i++) begin
      beat({rnd_h(), rnd_h()}, 16'($urandom), 1'b1);
      idle($urandom_range(0, 2));
    end
    idle(8);
    compare_writes("random");
    chk("clip_random", clip_count_out, clip_exp);

    beat({rnd_h(), rnd_h()}, 16'($urandom), 1'b1);
    beat({rnd_h(), rnd_h()}, 16'($urandom), 1'b1);
    frame_complete_in = 1'b1;
    beat({rnd_h(), rnd_h()}, 16'($urandom), 1'b1);
    frame_complete_in = 1'b0;
    wait_level(1'b1, 50, "swap_rise");
    chk("front_swapped", front_buffer_out, 1);
    chk("clip_zeroed", clip_count_out, 0);
    clip_exp = 0;
    expect_clear(0);
    back_base = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      frame_complete_in = (i == 4 || i == 6);
      beat({rnd_h(), rnd_h()}, 16'($urandom), i < DEPTH);
      frame_complete_in = 1'b0;
    end
    expect_clear(NPIX);
    wait_level(1'b0, NPIX + 50, "clear1_done");
    chk("drop_count", drop_count_out, 2);
    wait_level(1'b1, 60, "pending_swap");
    chk("front_pending", front_buffer_out, 0);
    wait_level(1'b0, NPIX + 50, "clear2_done");
    idle(10);
    chk("single_pending_front", front_buffer_out, 0);
    chk("single_pending_clearing", clearing_out, 0);
    chk("clip_after_pending", clip_count_out, 0);
    compare_writes("frame_seq");

    beat({rnd_h(), rnd_h()}, 16'($urandom), 1'b0);
    rst_in = 1'b1;
    #2;
    chk("async_rst_drop", drop_count_out, 0);
    chk("async_rst_clearing", clearing_out, 1);
    chk("async_rst_we", fb_we_out, 0);
    chk("async_rst_front", front_buffer_out, 0);
    idle(2);
    rst_in = 1'b0;
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
